// File: rtl/mem_access_stage.sv
// MEM pipeline stage: resolves beq/bne, runs loads/stores over a req/ack data-memory
// handshake while stalling upstream, and registers the results bound for write-back.
module mem_access_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WAIT_LIMIT = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  Valid_In,
    input  logic                  RegWriteEN_In,
    input  logic                  Mem2RegSEL_In,
    input  logic                  MemWriteEN_In,
    input  logic                  Beq_In,
    input  logic                  Bne_In,
    input  logic                  ZeroFlag_In,
    input  logic [DATA_W-1:0]     ALUResult_In,
    input  logic [DATA_W-1:0]     WriteData_In,
    input  logic [REG_ADDR_W-1:0] WriteBackRegAddr_In,
    input  logic [DATA_W-1:0]     PC_In,
    output logic                  Stall_Out,
    output logic                  DMemReq,
    output logic                  DMemWE,
    output logic [DATA_W-1:0]     DMemAddr,
    output logic [DATA_W-1:0]     DMemWData,
    input  logic                  DMemAck,
    input  logic [DATA_W-1:0]     DMemRData,
    output logic                  Redirect_Out,
    output logic [DATA_W-1:0]     BranchTarget_Out,
    output logic                  Flush_Out,
    output logic                  Valid_Out,
    output logic                  RegWriteEN_Out,
    output logic                  Mem2RegSEL_Out,
    output logic [DATA_W-1:0]     ALUResult_Out,
    output logic [DATA_W-1:0]     ReadData_Out,
    output logic [REG_ADDR_W-1:0] WriteBackRegAddr_Out,
    output logic                  MemError_Out
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        waitCnt_q, waitCnt_d;

    logic                    dmemReq_q, dmemReq_d;
    logic                    dmemWe_q, dmemWe_d;
    logic [DATA_W-1:0]       dmemAddr_q, dmemAddr_d;
    logic [DATA_W-1:0]       dmemWData_q, dmemWData_d;

    logic                    pendRegWrite_q, pendRegWrite_d;
    logic                    pendMem2Reg_q, pendMem2Reg_d;
    logic [DATA_W-1:0]       pendAlu_q, pendAlu_d;
    logic [REG_ADDR_W-1:0]   pendRd_q, pendRd_d;

    logic                    valid_q, valid_d;
    logic                    regWrite_q, regWrite_d;
    logic                    mem2Reg_q, mem2Reg_d;
    logic [DATA_W-1:0]       aluResult_q, aluResult_d;
    logic [DATA_W-1:0]       readData_q, readData_d;
    logic [REG_ADDR_W-1:0]   wbAddr_q, wbAddr_d;
    logic                    redirect_q, redirect_d;
    logic [DATA_W-1:0]       target_q, target_d;
    logic                    memError_q, memError_d;

    logic                    isBranch;
    logic                    isMemOp;
    logic                    branchTaken;

    // Branches never touch memory, even if a memory bit is set alongside them.
    assign isBranch    = Beq_In | Bne_In;
    assign isMemOp     = (Mem2RegSEL_In | MemWriteEN_In) & ~isBranch;
    assign branchTaken = (Beq_In & ZeroFlag_In) | (Bne_In & ~ZeroFlag_In);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            waitCnt_q      <= '0;
            dmemReq_q      <= 1'b0;
            dmemWe_q       <= 1'b0;
            dmemAddr_q     <= '0;
            dmemWData_q    <= '0;
            pendRegWrite_q <= 1'b0;
            pendMem2Reg_q  <= 1'b0;
            pendAlu_q      <= '0;
            pendRd_q       <= '0;
            valid_q        <= 1'b0;
            regWrite_q     <= 1'b0;
            mem2Reg_q      <= 1'b0;
            aluResult_q    <= '0;
            readData_q     <= '0;
            wbAddr_q       <= '0;
            redirect_q     <= 1'b0;
            target_q       <= '0;
            memError_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            waitCnt_q      <= waitCnt_d;
            dmemReq_q      <= dmemReq_d;
            dmemWe_q       <= dmemWe_d;
            dmemAddr_q     <= dmemAddr_d;
            dmemWData_q    <= dmemWData_d;
            pendRegWrite_q <= pendRegWrite_d;
            pendMem2Reg_q  <= pendMem2Reg_d;
            pendAlu_q      <= pendAlu_d;
            pendRd_q       <= pendRd_d;
            valid_q        <= valid_d;
            regWrite_q     <= regWrite_d;
            mem2Reg_q      <= mem2Reg_d;
            aluResult_q    <= aluResult_d;
            readData_q     <= readData_d;
            wbAddr_q       <= wbAddr_d;
            redirect_q     <= redirect_d;
            target_q       <= target_d;
            memError_q     <= memError_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        waitCnt_d      = waitCnt_q;
        dmemReq_d      = dmemReq_q;
        dmemWe_d       = dmemWe_q;
        dmemAddr_d     = dmemAddr_q;
        dmemWData_d    = dmemWData_q;
        pendRegWrite_d = pendRegWrite_q;
        pendMem2Reg_d  = pendMem2Reg_q;
        pendAlu_d      = pendAlu_q;
        pendRd_d       = pendRd_q;
        valid_d        = 1'b0;
        regWrite_d     = regWrite_q;
        mem2Reg_d      = mem2Reg_q;
        aluResult_d    = aluResult_q;
        readData_d     = readData_q;
        wbAddr_d       = wbAddr_q;
        redirect_d     = 1'b0;
        target_d       = target_q;
        memError_d     = memError_q;

        unique case (state_q)
            IDLE: begin
                if (Valid_In) begin
                    if (isMemOp) begin
                        state_d        = ACCESS;
                        waitCnt_d      = '0;
                        dmemReq_d      = 1'b1;
                        dmemWe_d       = MemWriteEN_In;
                        dmemAddr_d     = ALUResult_In;
                        dmemWData_d    = WriteData_In;
                        pendRegWrite_d = RegWriteEN_In;
                        pendMem2Reg_d  = Mem2RegSEL_In;
                        pendAlu_d      = ALUResult_In;
                        pendRd_d       = WriteBackRegAddr_In;
                    end else begin
                        valid_d     = 1'b1;
                        regWrite_d  = RegWriteEN_In;
                        mem2Reg_d   = Mem2RegSEL_In;
                        aluResult_d = ALUResult_In;
                        readData_d  = '0;
                        wbAddr_d    = WriteBackRegAddr_In;
                        if (branchTaken) begin
                            redirect_d = 1'b1;
                            target_d   = PC_In;
                        end
                    end
                end
            end

            ACCESS: begin
                if (DMemAck) begin
                    state_d     = IDLE;
                    dmemReq_d   = 1'b0;
                    dmemWe_d    = 1'b0;
                    valid_d     = 1'b1;
                    regWrite_d  = pendRegWrite_q;
                    mem2Reg_d   = pendMem2Reg_q;
                    aluResult_d = pendAlu_q;
                    wbAddr_d    = pendRd_q;
                    readData_d  = pendMem2Reg_q ? DMemRData : '0;
                end else if (waitCnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    // The last allowed cycle went by without an ack: abandon the access.
                    state_d    = IDLE;
                    dmemReq_d  = 1'b0;
                    dmemWe_d   = 1'b0;
                    regWrite_d = 1'b0;
                    memError_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign Stall_Out            = (state_q == ACCESS);
    assign DMemReq              = dmemReq_q;
    assign DMemWE               = dmemWe_q;
    assign DMemAddr             = dmemAddr_q;
    assign DMemWData            = dmemWData_q;
    assign Redirect_Out         = redirect_q;
    assign Flush_Out            = redirect_q;
    assign BranchTarget_Out     = target_q;
    assign Valid_Out            = valid_q;
    assign RegWriteEN_Out       = regWrite_q;
    assign Mem2RegSEL_Out       = mem2Reg_q;
    assign ALUResult_Out        = aluResult_q;
    assign ReadData_Out         = readData_q;
    assign WriteBackRegAddr_Out = wbAddr_q;
    assign MemError_Out         = memError_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a per-instruction outcome model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_access_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int WAIT_LIMIT = 16;

    logic                  CLOCK = 1'b0;
    logic                  RESET_N = 1'b0;
    logic                  Valid_In = 1'b0;
    logic                  RegWriteEN_In = 1'b0;
    logic                  Mem2RegSEL_In = 1'b0;
    logic                  MemWriteEN_In = 1'b0;
    logic                  Beq_In = 1'b0;
    logic                  Bne_In = 1'b0;
    logic                  ZeroFlag_In = 1'b0;
    logic [DATA_W-1:0]     ALUResult_In = '0;
    logic [DATA_W-1:0]     WriteData_In = '0;
    logic [REG_ADDR_W-1:0] WriteBackRegAddr_In = '0;
    logic [DATA_W-1:0]     PC_In = '0;
    logic                  DMemAck = 1'b0;
    logic [DATA_W-1:0]     DMemRData = '0;

    logic                  Stall_Out;
    logic                  DMemReq;
    logic                  DMemWE;
    logic [DATA_W-1:0]     DMemAddr;
    logic [DATA_W-1:0]     DMemWData;
    logic                  Redirect_Out;
    logic [DATA_W-1:0]     BranchTarget_Out;
    logic                  Flush_Out;
    logic                  Valid_Out;
    logic                  RegWriteEN_Out;
    logic                  Mem2RegSEL_Out;
    logic [DATA_W-1:0]     ALUResult_Out;
    logic [DATA_W-1:0]     ReadData_Out;
    logic [REG_ADDR_W-1:0] WriteBackRegAddr_Out;
    logic                  MemError_Out;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK = ~CLOCK;

    mem_access_stage #(
        .DATA_W    (DATA_W),
        .REG_ADDR_W(REG_ADDR_W),
        .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .CLOCK               (CLOCK),
        .RESET_N             (RESET_N),
        .Valid_In            (Valid_In),
        .RegWriteEN_In       (RegWriteEN_In),
        .Mem2RegSEL_In       (Mem2RegSEL_In),
        .MemWriteEN_In       (MemWriteEN_In),
        .Beq_In              (Beq_In),
        .Bne_In              (Bne_In),
        .ZeroFlag_In         (ZeroFlag_In),
        .ALUResult_In        (ALUResult_In),
        .WriteData_In        (WriteData_In),
        .WriteBackRegAddr_In (WriteBackRegAddr_In),
        .PC_In               (PC_In),
        .Stall_Out           (Stall_Out),
        .DMemReq             (DMemReq),
        .DMemWE              (DMemWE),
        .DMemAddr            (DMemAddr),
        .DMemWData           (DMemWData),
        .DMemAck             (DMemAck),
        .DMemRData           (DMemRData),
        .Redirect_Out        (Redirect_Out),
        .BranchTarget_Out    (BranchTarget_Out),
        .Flush_Out           (Flush_Out),
        .Valid_Out           (Valid_Out),
        .RegWriteEN_Out      (RegWriteEN_Out),
        .Mem2RegSEL_Out      (Mem2RegSEL_Out),
        .ALUResult_Out       (ALUResult_Out),
        .ReadData_Out        (ReadData_Out),
        .WriteBackRegAddr_Out(WriteBackRegAddr_Out),
        .MemError_Out        (MemError_Out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks each instruction's fate (immediate result, memory wait, abort).
    bit                    mBusy;
    int                    mWait;
    logic                  pLoad, pRegW;
    logic [DATA_W-1:0]     pAlu;
    logic [REG_ADDR_W-1:0] pRd;
    logic                  expValid, expReq, expWe, expRedirect, expErr;
    logic                  expRegW, expM2R, expReadChk;
    logic [DATA_W-1:0]     expAddr, expWData, expAlu, expRead, expTarget;
    logic [REG_ADDR_W-1:0] expRd;
    logic                  mBranch, mMem;

    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            mBusy = 0; mWait = 0;
            expValid = 0; expReq = 0; expWe = 0; expRedirect = 0; expErr = 0;
            expRegW = 0; expM2R = 0; expReadChk = 0;
            expAddr = '0; expWData = '0; expAlu = '0; expRead = '0; expTarget = '0; expRd = '0;
        end else begin
            expValid    = 0;
            expRedirect = 0;
            if (mBusy) begin
                if (DMemAck) begin
                    mBusy = 0; expReq = 0; expWe = 0;
                    expValid = 1; expRegW = pRegW; expM2R = pLoad;
                    expAlu = pAlu; expRd = pRd; expReadChk = 1;
                    expRead = pLoad ? DMemRData : '0;
                end else begin
                    mWait++;
                    if (mWait == WAIT_LIMIT) begin
                        mBusy = 0; expReq = 0; expWe = 0; expRegW = 0; expErr = 1;
                    end
                end
            end else if (Valid_In) begin
                mBranch = Beq_In | Bne_In;
                mMem    = (Mem2RegSEL_In | MemWriteEN_In) & ~mBranch;
                if (mMem) begin
                    mBusy = 1; mWait = 0;
                    expReq = 1; expWe = MemWriteEN_In;
                    expAddr = ALUResult_In; expWData = WriteData_In;
                    pLoad = Mem2RegSEL_In; pRegW = RegWriteEN_In;
                    pAlu = ALUResult_In; pRd = WriteBackRegAddr_In;
                end else begin
                    expValid = 1; expRegW = RegWriteEN_In; expM2R = Mem2RegSEL_In;
                    expAlu = ALUResult_In; expRd = WriteBackRegAddr_In; expReadChk = 0;
                    if ((Beq_In && ZeroFlag_In) || (Bne_In && !ZeroFlag_In)) begin
                        expRedirect = 1;
                        expTarget   = PC_In;
                    end
                end
            end
        end
    end

    always @(negedge CLOCK) begin
        checkOutput("Valid_Out", Valid_Out, expValid);
        checkOutput("Stall_Out", Stall_Out, mBusy);
        checkOutput("DMemReq", DMemReq, expReq);
        checkOutput("DMemWE", DMemWE, expWe);
        checkOutput("Redirect_Out", Redirect_Out, expRedirect);
        checkOutput("Flush_Out", Flush_Out, expRedirect);
        checkOutput("MemError_Out", MemError_Out, expErr);
        checkOutput("RegWriteEN_Out", RegWriteEN_Out, expRegW);
        if (expValid) begin
            checkOutput("Mem2RegSEL_Out", Mem2RegSEL_Out, expM2R);
            checkOutput("ALUResult_Out", ALUResult_Out, expAlu);
            checkOutput("WriteBackRegAddr_Out", WriteBackRegAddr_Out, expRd);
            if (expReadChk) checkOutput("ReadData_Out", ReadData_Out, expRead);
        end
        if (expReq) begin
            checkOutput("DMemAddr", DMemAddr, expAddr);
            checkOutput("DMemWData", DMemWData, expWData);
        end
        if (expRedirect) checkOutput("BranchTarget_Out", BranchTarget_Out, expTarget);
    end

    task automatic applyStimulus(input logic v, input logic rw, input logic m2r, input logic mwe,
                                 input logic beq, input logic bne, input logic zero,
                                 input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic [31:0] pc);
        Valid_In = v; RegWriteEN_In = rw; Mem2RegSEL_In = m2r; MemWriteEN_In = mwe;
        Beq_In = beq; Bne_In = bne; ZeroFlag_In = zero;
        ALUResult_In = alu; WriteData_In = wd; WriteBackRegAddr_In = rd; PC_In = pc;
    endtask

    task automatic step();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic clearInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    // Holds ack low for noAck cycles, then acks once; returns how many stall cycles were seen.
    task automatic runAccess(input int noAck, input logic [31:0] rdata, output int stallSeen);
        stallSeen = 0;
        for (int c = 0; c < noAck; c++) begin
            if (Stall_Out) stallSeen++;
            @(negedge CLOCK);
        end
        if (Stall_Out) stallSeen++;
        DMemAck = 1'b1; DMemRData = rdata;
        @(negedge CLOCK);
        DMemAck = 1'b0; DMemRData = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        int validSeen;
        logic [31:0] aluVec [4];
        logic [4:0]  rdVec  [4];
        aluVec[0] = 32'h0000_0001; rdVec[0] = 5'd1;
        aluVec[1] = 32'hFFFF_FFFF; rdVec[1] = 5'd31;
        aluVec[2] = 32'h1234_5678; rdVec[2] = 5'd17;
        aluVec[3] = 32'h8000_0000; rdVec[3] = 5'd0;

        #1;
        checkOutput("reset Valid_Out", Valid_Out, 1'b0);
        checkOutput("reset Stall_Out", Stall_Out, 1'b0);
        checkOutput("reset DMemReq", DMemReq, 1'b0);
        checkOutput("reset ALUResult_Out", ALUResult_Out, 32'h0);
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);

        // ALU op: one-cycle latency, no stall.
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h2A, 32'h0, 5'd3, 32'h0);
        step();
        clearInputs();
        checkOutput("alu Valid_Out", Valid_Out, 1'b1);
        checkOutput("alu ALUResult_Out", ALUResult_Out, 32'h2A);
        checkOutput("alu WriteBackRegAddr_Out", WriteBackRegAddr_Out, 5'd3);
        checkOutput("alu Stall_Out", Stall_Out, 1'b0);
        step();
        checkOutput("alu Valid_Out pulse", Valid_Out, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, i[0], 0, 0, 0, 0, 0, aluVec[i], 32'h0, rdVec[i], 32'h0);
            step();
        end
        clearInputs();
        step();

        // Load with ack 3 cycles after request; next ALU op held upstream meanwhile.
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h100, 32'h0, 5'd9, 32'h0);
        step();
        checkOutput("load DMemReq", DMemReq, 1'b1);
        checkOutput("load DMemAddr", DMemAddr, 32'h100);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h77, 32'h0, 5'd7, 32'h0);
        runAccess(3, 32'hDEADBEEF, stalls);
        checkOutput("load stall cycles", stalls, 32'd4);
        checkOutput("load Valid_Out", Valid_Out, 1'b1);
        checkOutput("load ReadData_Out", ReadData_Out, 32'hDEADBEEF);
        checkOutput("load ALUResult_Out", ALUResult_Out, 32'h100);
        checkOutput("load DMemReq dropped", DMemReq, 1'b0);
        step();
        clearInputs();
        checkOutput("held ALU ALUResult_Out", ALUResult_Out, 32'h77);
        checkOutput("held ALU Valid_Out", Valid_Out, 1'b1);
        step();

        // Store with immediate ack.
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 32'h40, 32'h55, 5'd0, 32'h0);
        step();
        clearInputs();
        checkOutput("store DMemWE", DMemWE, 1'b1);
        checkOutput("store DMemWData", DMemWData, 32'h55);
        runAccess(0, 32'hCAFE_F00D, stalls);
        checkOutput("store stall cycles", stalls, 32'd1);
        checkOutput("store DMemWE dropped", DMemWE, 1'b0);
        checkOutput("store Valid_Out", Valid_Out, 1'b1);
        checkOutput("store RegWriteEN_Out", RegWriteEN_Out, 1'b0);
        checkOutput("store ReadData_Out", ReadData_Out, 32'h0);
        step();

        // Branches: beq taken, bne not taken, bne taken, beq not taken.
        applyStimulus(1, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 5'd0, 32'h80);
        step();
        checkOutput("beq Redirect_Out", Redirect_Out, 1'b1);
        checkOutput("beq Flush_Out", Flush_Out, 1'b1);
        checkOutput("beq BranchTarget_Out", BranchTarget_Out, 32'h80);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h90);
        step();
        checkOutput("bne zero Redirect_Out", Redirect_Out, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0, 32'hA0);
        step();
        checkOutput("bne nonzero BranchTarget_Out", BranchTarget_Out, 32'hA0);
        applyStimulus(1, 0, 1, 0, 1, 0, 0, 32'h0, 32'h0, 5'd0, 32'hB0);
        step();
        clearInputs();
        checkOutput("beq nonzero Redirect_Out", Redirect_Out, 1'b0);
        checkOutput("branch never stalls", Stall_Out, 1'b0);
        step();

        // Load that is never acknowledged.
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h200, 32'h0, 5'd5, 32'h0);
        step();
        clearInputs();
        stalls = 0; validSeen = 0;
        for (int c = 0; c < WAIT_LIMIT + 4; c++) begin
            if (Stall_Out) stalls++;
            if (Valid_Out) validSeen++;
            @(negedge CLOCK);
        end
        checkOutput("timeout stall cycles", stalls, 32'd16);
        checkOutput("timeout Valid_Out count", validSeen, 32'd0);
        checkOutput("timeout MemError_Out", MemError_Out, 1'b1);
        checkOutput("timeout RegWriteEN_Out", RegWriteEN_Out, 1'b0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h33, 32'h0, 5'd4, 32'h0);
        step();
        clearInputs();
        checkOutput("sticky MemError_Out", MemError_Out, 1'b1);

        // Reset in the middle of an access.
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h300, 32'h0, 5'd6, 32'h0);
        step();
        clearInputs();
        @(negedge CLOCK);
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("rst DMemReq", DMemReq, 1'b0);
        checkOutput("rst Stall_Out", Stall_Out, 1'b0);
        checkOutput("rst MemError_Out", MemError_Out, 1'b0);
        checkOutput("rst ALUResult_Out", ALUResult_Out, 32'h0);
        checkOutput("rst WriteBackRegAddr_Out", WriteBackRegAddr_Out, 5'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 32'h5A5A, 32'h0, 5'd12, 32'h0);
        step();
        clearInputs();
        checkOutput("post-rst Valid_Out", Valid_Out, 1'b1);
        checkOutput("post-rst ALUResult_Out", ALUResult_Out, 32'h5A5A);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
